// File: rtl/cmul_vedic_pipe.sv
// -----------------------------------------------------------------------------
// cmul_vedic_pipe -- pipelined signed complex multiplier
//   (ar + j*ai) * (br + j*bi) -> pr + j*pi
//
// Four unsigned W x W vedic cores (recursive hi/lo decomposition down to 2x2
// leaves) work on operand magnitudes. Signs are reapplied after the products
// are formed. The three-stage datapath sits behind a valid/ready stream
// handshake. A stall (out_valid && !out_ready) freezes every stage.
//
// Parameters
//   W          operand width per component. Must be a power of 2 and >= 4.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands valid          in_ready   operands accepted this cycle
//   ar, ai     A real/imag (W, signed) br, bi     B real/imag (W, signed)
//   out_valid  result valid            out_ready  downstream accepts result
//   pr, pi     real/imag result (2W+1, signed)
//   in_conj    (CMUL_CONJ_EN only) compute A * conj(B) for this operand set
//
// Optional build macro: CMUL_CONJ_EN adds the in_conj input.
// -----------------------------------------------------------------------------

// Unsigned N x N vedic multiplier, combinational, recursive down to 2 x 2.
module cmul_vedic_core #(
    parameter int N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    generate
        if (N == 2) begin : g_leaf
            logic w_t1, w_t2, w_t3, w_c1;
            assign w_t1 = a[1] & b[0];
            assign w_t2 = a[0] & b[1];
            assign w_t3 = a[1] & b[1];
            assign w_c1 = w_t1 & w_t2;
            assign p    = {w_t3 & w_c1, w_t3 ^ w_c1, w_t1 ^ w_t2, a[0] & b[0]};
        end else begin : g_split
            localparam int H = N / 2;
            logic [N-1:0] w_ll, w_lh, w_hl, w_hh;
            logic [N:0]   w_mid;

            cmul_vedic_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(w_ll));
            cmul_vedic_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(w_lh));
            cmul_vedic_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(w_hl));
            cmul_vedic_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(w_hh));

            // Cross terms carry one extra bit before being shifted by H.
            // {hh, ll} already places hh at shift N and ll at shift 0.
            assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
            assign p     = {w_hh, w_ll} + {{(H-1){1'b0}}, w_mid, {H{1'b0}}};
        end
    endgenerate
endmodule

module cmul_vedic_pipe #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   ar,
    input  logic [W-1:0]   ai,
    input  logic [W-1:0]   br,
    input  logic [W-1:0]   bi,
`ifdef CMUL_CONJ_EN
    input  logic           in_conj,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W:0]   pr,
    output logic [2*W:0]   pi
);
    generate
        if (W < 4 || (W & (W - 1)) != 0) begin : g_bad_width
            $error("cmul_vedic_pipe: W must be a power of 2 and >= 4");
        end
    endgenerate

    logic           w_stall;
    logic           w_conj;
    logic [W-1:0]   w_op   [4];   // 0:ar 1:ai 2:br 3:bi
    logic [W-1:0]   w_mag  [4];
    logic           w_sgn  [4];
    logic [2*W-1:0] w_prod [4];   // 0:rr 1:ii 2:ri 3:ir
    logic [2*W:0]   w_sgd  [4];

    logic           r_v1, r_v2, r_v3;
    logic [W-1:0]   r_mag1 [4];
    logic           r_sgn1 [4];
    logic [2*W:0]   r_p2   [4];
    logic [2*W:0]   r_pr, r_pi;

`ifdef CMUL_CONJ_EN
    assign w_conj = in_conj;
`else
    assign w_conj = 1'b0;
`endif

    assign w_stall   = r_v3 && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_v3;
    assign pr        = r_pr;
    assign pi        = r_pi;

    assign w_op[0] = ar;
    assign w_op[1] = ai;
    assign w_op[2] = br;
    assign w_op[3] = bi;

    genvar gi;
    generate
        // S1: magnitude and sign per operand. Negating -2^(W-1) wraps back to
        // 2^(W-1), which is the correct unsigned magnitude.
        for (gi = 0; gi < 4; gi++) begin : g_s1
            assign w_mag[gi] = w_op[gi][W-1] ? -w_op[gi] : w_op[gi];
            // Conjugation only flips the sign of bi; magnitude is untouched.
            assign w_sgn[gi] = w_op[gi][W-1] ^ ((gi == 3) ? w_conj : 1'b0);

            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    r_mag1[gi] <= w_mag[gi];
                    r_sgn1[gi] <= w_sgn[gi];
                end
            end
        end

        // S2: product lanes rr=(ar,br) ii=(ai,bi) ri=(ar,bi) ir=(ai,br).
        for (gi = 0; gi < 4; gi++) begin : g_s2
            localparam int A_IDX = gi % 2;
            localparam int B_IDX = (gi == 1 || gi == 2) ? 3 : 2;
            logic w_neg;

            cmul_vedic_core #(.N(W)) u_core (
                .a (r_mag1[A_IDX]),
                .b (r_mag1[B_IDX]),
                .p (w_prod[gi])
            );

            assign w_neg     = r_sgn1[A_IDX] ^ r_sgn1[B_IDX];
            assign w_sgd[gi] = w_neg ? -{1'b0, w_prod[gi]} : {1'b0, w_prod[gi]};

            always_ff @(posedge clk) begin
                if (!w_stall) begin
                    r_p2[gi] <= w_sgd[gi];
                end
            end
        end
    endgenerate

    // Valid bits and the S3 result. Only these carry reset; the other data
    // registers are don't-care while their valid bit is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_pr <= '0;
            r_pi <= '0;
        end else if (!w_stall) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_pr <= r_p2[0] - r_p2[1];
            r_pi <= r_p2[2] + r_p2[3];
        end
    end
endmodule

// File: tb/tb_cmul_vedic_pipe.sv
module tb_cmul_vedic_pipe;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   ar, ai, br, bi;
    logic           in_conj;
    logic           out_valid;
    logic           out_ready;
    logic [2*W:0]   pr, pi;

    typedef struct packed {
        logic [2*W:0] pr;
        logic [2*W:0] pi;
    } res_t;

    res_t q[$];
    res_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    // Directed table: ar, ai, br, bi and the expected pr, pi.
    logic [W-1:0] tv_ar [4] = '{16'd3,    16'h0FFC, 16'h8000, 16'h7FFF};
    logic [W-1:0] tv_ai [4] = '{16'd4,    16'h0000, 16'h8000, 16'h0000};
    logic [W-1:0] tv_br [4] = '{16'd5,    16'hF003, 16'h8000, 16'h8000};
    logic [W-1:0] tv_bi [4] = '{16'hFFFE, 16'h0000, 16'h8000, 16'h0000};
    logic [2*W:0] tv_pr [4] = '{33'd23, -33'sd16748556, 33'd0, -33'sd1073709056};
    logic [2*W:0] tv_pi [4] = '{33'd14, 33'd0, 33'h0_8000_0000, 33'd0};

    cmul_vedic_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
`ifdef CMUL_CONJ_EN
        .in_conj   (in_conj),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pr        (pr),
        .pi        (pi)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model, plain integer arithmetic.
    function automatic res_t model(input logic [W-1:0] a_r, input logic [W-1:0] a_i,
                                   input logic [W-1:0] b_r, input logic [W-1:0] b_i,
                                   input logic cj);
        longint sar, sai, sbr, sbi, r, i;
        res_t   m;
        sar = longint'($signed(a_r));
        sai = longint'($signed(a_i));
        sbr = longint'($signed(b_r));
        sbi = longint'($signed(b_i));
        if (cj) sbi = -sbi;
        r = sar * sbr - sai * sbi;
        i = sar * sbi + sai * sbr;
        m.pr = r[2*W:0];
        m.pi = i[2*W:0];
        return m;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // Scoreboard: every output transfer pops and compares in order.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_out++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output pr=%0d pi=%0d, required no output (queue empty)",
                         $signed(pr), $signed(pi));
            end else begin
                mon_e = q.pop_front();
                if (pr !== mon_e.pr || pi !== mon_e.pi) begin
                    errors++;
                    $display("FAIL result pr=%0d pi=%0d, required pr=%0d pi=%0d",
                             $signed(pr), $signed(pi), $signed(mon_e.pr), $signed(mon_e.pi));
                end
            end
        end
    end

    // Presents one operand set and holds it until accepted (bounded).
    task automatic send(input logic [W-1:0] a_r, input logic [W-1:0] a_i,
                        input logic [W-1:0] b_r, input logic [W-1:0] b_i, input logic cj);
        bit done = 0;
        ar = a_r; ai = a_i; br = b_r; bi = b_i; in_conj = cj;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                q.push_back(model(a_r, a_i, b_r, b_i, cj));
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout in_ready=%b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_conj = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || pr !== '0 || pi !== '0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b pr=%0d pi=%0d, required 0 0 0",
                     out_valid, pr, pi);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_latency();
        out_ready = 1'b1;
        ar = 16'd3; ai = 16'd4; br = 16'd5; bi = 16'hFFFE; in_conj = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        q.push_back(model(ar, ai, br, bi, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (out_valid !== (c == 3)) begin
                errors++;
                $display("FAIL latency cycle %0d out_valid=%b, required %b", c, out_valid, c == 3);
            end
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (pr !== 33'd23 || pi !== 33'd14) begin
            errors++;
            $display("FAIL basic pr=%0d pi=%0d, required 23 14", $signed(pr), $signed(pi));
        end
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain pending=%0d, required 0", q.size());
        end
    endtask

    task automatic test_vectors();
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            send(tv_ar[t], tv_ai[t], tv_br[t], tv_bi[t], 1'b0);
            in_valid = 1'b0;
            for (int k = 0; k < 10 && out_valid !== 1'b1; k++) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (out_valid !== 1'b1 || pr !== tv_pr[t] || pi !== tv_pi[t]) begin
                errors++;
                $display("FAIL vector%0d out_valid=%b pr=%0d pi=%0d, required 1 %0d %0d", t,
                         out_valid, $signed(pr), $signed(pi), $signed(tv_pr[t]), $signed(tv_pi[t]));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        int      start = n_out;
        bit      saw_low = 0;
        bit      release_now = 0;
        int      stall_cyc = 0;
        logic [2*W:0] hold_pr, hold_pi;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit done = 0;
            ar = rand_op(); ai = rand_op(); br = rand_op(); bi = rand_op(); in_conj = 1'b0;
            in_valid = 1'b1;
            if (i == 2) out_ready = 1'b0;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                if (in_ready === 1'b1) begin
                    q.push_back(model(ar, ai, br, bi, 1'b0));
                    done = 1;
                end else begin
                    saw_low = 1;
                    stall_cyc++;
                    if (stall_cyc == 1) begin
                        hold_pr = pr;
                        hold_pi = pi;
                    end else begin
                        checks++;
                        if (pr !== hold_pr || pi !== hold_pi || out_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL stall_stable pr=%0d pi=%0d out_valid=%b, required %0d %0d 1",
                                     $signed(pr), $signed(pi), out_valid,
                                     $signed(hold_pr), $signed(hold_pi));
                        end
                    end
                    if (stall_cyc == 5) release_now = 1;
                end
                @(posedge clk);
                #1;
                if (release_now) out_ready = 1'b1;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL b2b_timeout item %0d in_ready=%b, required 1", i, in_ready);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!saw_low) begin
            errors++;
            $display("FAIL b2b_in_ready_low saw_low=0, required 1");
        end
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0 || n_out - start != 6) begin
            errors++;
            $display("FAIL b2b_count outputs=%0d pending=%0d, required 6 0", n_out - start, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int start;
        out_ready = 1'b1;
        send(16'd7, 16'd9, 16'd11, 16'd13, 1'b0);
        send(16'h1234, 16'hF00F, 16'h0F0F, 16'h8001, 1'b0);
        // Reset together with a valid input: the input must not be captured.
        rst = 1'b1;
        ar = 16'd100; ai = 16'd1; br = 16'd2; bi = 16'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        checks++;
        if (out_valid !== 1'b0 || pr !== '0 || pi !== '0) begin
            errors++;
            $display("FAIL midreset_state out_valid=%b pr=%0d pi=%0d, required 0 0 0",
                     out_valid, pr, pi);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready in_ready=%b, required 1", in_ready);
        end
        start = n_out;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d out_valid=%b, required 0", c, out_valid);
            end
        end
        send(16'hFFFD, 16'd2, 16'd6, 16'hFFF9, 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0 || n_out - start != 1) begin
            errors++;
            $display("FAIL midreset_count outputs=%0d pending=%0d, required 1 0",
                     n_out - start, q.size());
        end
    endtask

`ifdef CMUL_CONJ_EN
    task automatic test_conj();
        out_ready = 1'b1;
        send(16'd3, 16'd4, 16'd5, 16'hFFFE, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && out_valid !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1 || pr !== 33'd7 || pi !== 33'd26) begin
            errors++;
            $display("FAIL conj_basic pr=%0d pi=%0d, required 7 26", $signed(pr), $signed(pi));
        end
        @(posedge clk);
        #1;
        send(16'd1, 16'd0, 16'd0, 16'h8000, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && out_valid !== 1'b1; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1 || pr !== 33'd0 || pi !== 33'd32768) begin
            errors++;
            $display("FAIL conj_min pr=%0d pi=%0d, required 0 32768", $signed(pr), $signed(pi));
        end
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_random();
        int start = n_out;
        int sent  = 0;
        bit xfer  = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000 && sent < 40; c++) begin
            if (xfer) in_valid = 1'b0;
            xfer = 0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                ar = rand_op(); ai = rand_op(); br = rand_op(); bi = rand_op();
`ifdef CMUL_CONJ_EN
                in_conj = 1'($urandom_range(0, 1));
`else
                in_conj = 1'b0;
`endif
                in_valid = 1'b1;
            end
            @(negedge clk);
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model(ar, ai, br, bi, in_conj));
                sent++;
                xfer = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        #1;
        checks++;
        if (sent != 40 || q.size() != 0 || n_out - start != 40) begin
            errors++;
            $display("FAIL random_count sent=%0d outputs=%0d pending=%0d, required 40 40 0",
                     sent, n_out - start, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_vectors();
        test_back_to_back();
        test_reset_midflight();
`ifdef CMUL_CONJ_EN
        test_conj();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmul_vedic_pipe.md
Name: cmul_vedic_pipe

Overview:
- Parametrised, pipelined signed complex multiplier: (ar + j·ai) × (br + j·bi).
- Built from four unsigned W×W vedic multiplier cores, generated recursively down to 2×2 leaves.
- Extends the fixed 16-bit combinational vedic multiplier in three ways: width is a parameter, operands are signed, and the datapath is registered behind a valid/ready stream handshake with backpressure.
- Sits between the complex sample source and the accumulator stage of the complex-multiplier datapath.

Parameters:
- W, 16, operand width per real/imag component. Must be a power of 2 and ≥ 4; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands this cycle.
- ar  in  W  A real part, two's complement.
- ai  in  W  A imag part, two's complement.
- br  in  W  B real part, two's complement.
- bi  in  W  B imag part, two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- pr  out  2W+1  real result = ar·br − ai·bi, two's complement.
- pi  out  2W+1  imag result = ar·bi + ai·br, two's complement.

Behaviour:
- Transfer rules: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall, combinational. A stall freezes all pipeline registers, including valid bits.
- Pipeline, 3 stages, one valid bit per stage, advancing when !stall:
  - S1: register unsigned magnitudes |ar|, |ai|, |br|, |bi| (W bits each) and the sign bits. The magnitude of −2^(W−1) is 2^(W−1), which fits in W unsigned bits.
  - S2: four vedic cores produce 2W-bit unsigned products ar·br, ai·bi, ar·bi, ai·br. Each is sign-corrected (sign = XOR of the operand signs) into a 2W+1 signed value and registered.
  - S3: pr = p_rr − p_ii and pi = p_ri + p_ir, computed at 2W+1 bits and registered to the outputs.
- Vedic core: split each operand into hi/lo halves; form four half-width sub-products; sum with shifts of 0, W/2 and W. Recursion ends at 2×2 leaves.
- Latency: exactly 3 clk cycles from input transfer to out_valid, with no stall in between.
- Throughput: 1 result per cycle while out_ready = 1.
- Ordering: results leave in input order. No drop or duplication under any in_valid/out_ready pattern.
- Range: 2W+1 bits holds every result exactly. Worst case is pi = +2^(2W−1), which occurs when all inputs are −2^(W−1). No overflow or saturation is possible.
- Stability: while out_valid && !out_ready, pr and pi hold stable.
- Reset:
  - All stage valid bits clear to 0, so out_valid = 0.
  - pr = 0, pi = 0.
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation: in-flight data is discarded; no stale result ever appears afterwards.
- Simultaneous rst and in_valid: rst wins; the input is not captured.
- Bubbles: idle cycles (in_valid = 0) propagate as stage valid = 0. Data registers may update but are don't-care when their valid bit is 0.

Optional Feature:
- Macro: CMUL_CONJ_EN.
- Defined:
  - Adds input port in_conj (1 bit), sampled on input transfer and carried through S1.
  - When in_conj = 1, the block computes A × conj(B) by inverting the sign bit of bi in S1; the magnitude is unchanged, so bi = −2^(W−1) is handled correctly.
  - Results: pr = ar·br + ai·bi, pi = ai·br − ar·bi.
- Not defined: port in_conj is absent and behaviour equals in_conj = 0.

Test Plan (W = 16):
- Basic: A = 3+j4, B = 5−j2, out_ready = 1 → exactly 3 cycles later, out_valid = 1, pr = 23, pi = 14.
- Real-only: ar = 0x0FFC, ai = 0, br = 0xF003 (−4093), bi = 0 → pr = −16748556, pi = 0.
- Extremes: ar = ai = br = bi = 0x8000 → pr = 0, pi = +2147483648 (33-bit 0x0_8000_0000). Also ar = 0x7FFF, br = 0x8000, others 0 → pr = −1073709056.
- Backpressure: stream 6 back-to-back inputs with out_ready = 0 from cycle 2 →
  - in_ready falls once the pipeline fills;
  - pr and pi stay stable;
  - releasing out_ready yields all 6 results in order, no loss or duplication.
- Reset: 2 operations in flight, assert rst for 1 cycle →
  - next cycle out_valid = 0, pr = pi = 0, in_ready = 1;
  - only inputs sent after reset produce results.
- Conj (CMUL_CONJ_EN defined): A = 3+j4, B = 5−j2, in_conj = 1 → pr = 7, pi = 26. Also A = 1, bi = 0x8000, br = 0, in_conj = 1 → pi = +32768.
